uart_tx_fifo: RTL and testbench

- Serial transmit side of the 8N1 link whose receive side is the existing acia_rx (1200 baud from the 48 MHz xtal clock).
- Bytes are queued through a small FIFO and serialised onto the fpga_tx pin. Replies, hex dumps and status can be streamed back without the producer tracking bit timing.
- Bit timing parameters are identical to acia_rx, so one pair of localparams drives both ends.

---
 rtl/uart_tx_fifo.sv | 89 ++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 serial transmitter that shares its bit timing with acia_rx.
// Frames go out back to back while bytes are queued; tx_serial is registered one cycle behind the FSM state.
module uart_tx_fifo #(
  parameter int SCW       = 16,
  parameter int sym_cnt   = 40000,
  parameter int DEPTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               tx_dat,
  input  logic                     tx_stb,
  output logic                     tx_full,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic                     tx_ovf,
  output logic                     tx_busy,
  output logic                     tx_serial
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [SCW-1:0] LAST = SCW'(sym_cnt - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic [SCW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic r_serial, r_ovf;
  logic w_push, w_pop, w_tick;
  assign tx_full = r_level == (AW+1)'(DEPTH);
  assign w_push = tx_stb & ~tx_full;
  assign w_tick = r_cnt == LAST;
  assign tx_level = r_level;
  assign tx_ovf = r_ovf;
  assign tx_serial = r_serial;
  assign tx_busy = (r_state != IDLE) | (r_level != '0);
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = r_level != '0;
        w_next = w_pop ? START : IDLE;
      end
      START: w_next = w_tick ? DATA : START;
      DATA: w_next = (w_tick && r_bit == 3'd7) ? STOP : DATA;
      STOP: if (w_tick && r_bit == LAST_STOP) begin
        w_pop = r_level != '0;
        w_next = w_pop ? START : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= tx_dat;
  // r_bit indexes data bits in DATA and stop bits in STOP; a pop rearms both counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf <= 1'b0;
      r_serial <= 1'b1;
      r_shift <= '0;
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_wptr <= r_wptr + AW'(w_push);
      r_rptr <= r_rptr + AW'(w_pop);
      r_ovf <= tx_stb & tx_full;
      r_serial <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
        r_cnt <= '0;
        r_bit <= '0;
      end else if (r_state != IDLE) begin
        r_cnt <= w_tick ? '0 : r_cnt + SCW'(1);
        if (w_tick && r_state == DATA) r_shift <= r_shift >> 1;
        if (w_tick && r_state != START) r_bit <= r_bit + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo with 4-cycle bits, a 4-entry FIFO,
// and a second instance with two stop bits.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] dat = 8'h00;
  logic stb1 = 1'b0, stb2 = 1'b0;
  logic full1, ovf1, busy1, ser1;
  logic [2:0] lvl1;
  logic full2, ovf2, busy2, ser2;
  logic [2:0] lvl2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_tx_fifo #(.SCW(2), .sym_cnt(4), .DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_dat(dat), .tx_stb(stb1), .tx_full(full1),
    .tx_level(lvl1), .tx_ovf(ovf1), .tx_busy(busy1), .tx_serial(ser1));
  uart_tx_fifo #(.SCW(2), .sym_cnt(4), .DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_dat(dat), .tx_stb(stb2), .tx_full(full2),
    .tx_level(lvl2), .tx_ovf(ovf2), .tx_busy(busy2), .tx_serial(ser2));
  // expected line level u cycles into a frame whose start bit begins at u=0
  function automatic logic exp_bit(input logic [7:0] b, input int u);
    if (u < 4) return 1'b0;
    if (u < 36) return b[(u - 4) / 4];
    return 1'b1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (5) tick();
    total += 5;
    if (ser1 !== 1'b1) begin bad++; $display("FAIL reset_serial got=%b want=1", ser1); end
    if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
    if (lvl1 !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", lvl1); end
    if (full1 !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full1); end
    if (ovf1 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf1); end
    rst = 1'b1;
    repeat (2) tick();
  endtask
  task automatic test_single();
    for (int k = 0; k <= 43; k++) begin
      stb1 = (k == 0);
      dat = 8'hA5;
      tick();
      if (k == 0) begin
        total += 2;
        if (lvl1 !== 3'd1) begin bad++; $display("FAIL single_lvl0 got=%0d want=1", lvl1); end
        if (ser1 !== 1'b1) begin bad++; $display("FAIL single_ser_k0 got=%b want=1", ser1); end
      end
      if (k == 1) begin
        total += 2;
        if (lvl1 !== 3'd0) begin bad++; $display("FAIL single_lvl1 got=%0d want=0", lvl1); end
        if (ser1 !== 1'b1) begin bad++; $display("FAIL single_ser_k1 got=%b want=1", ser1); end
      end
      if (k >= 2 && k <= 41) begin
        total++;
        if (ser1 !== exp_bit(8'hA5, k - 2)) begin
          bad++; $display("FAIL single_line t=%0d got=%b want=%b", k - 2, ser1, exp_bit(8'hA5, k - 2));
        end
      end
      if (k >= 42) begin
        total++;
        if (ser1 !== 1'b1) begin bad++; $display("FAIL single_idle k=%0d got=%b want=1", k, ser1); end
      end
      if (k == 40 || k == 41) begin
        total++;
        if (busy1 !== (k == 40)) begin bad++; $display("FAIL single_busy k=%0d got=%b want=%b", k, busy1, k == 40); end
      end
    end
    stb1 = 1'b0;
  endtask
  task automatic test_burst();
    logic [7:0] seq [3];
    int peak = 0;
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03;
    for (int k = 0; k <= 121; k++) begin
      stb1 = (k < 3);
      if (k < 3) dat = seq[k];
      tick();
      if (int'(lvl1) > peak) peak = int'(lvl1);
      if (k >= 2) begin
        total++;
        if (ser1 !== exp_bit(seq[(k - 2) / 40], (k - 2) % 40)) begin
          bad++; $display("FAIL burst_line t=%0d got=%b want=%b", k - 2, ser1, exp_bit(seq[(k - 2) / 40], (k - 2) % 40));
        end
      end
      if (k == 120 || k == 121) begin
        total++;
        if (busy1 !== (k == 120)) begin bad++; $display("FAIL burst_busy k=%0d got=%b want=%b", k, busy1, k == 120); end
      end
    end
    stb1 = 1'b0;
    total++;
    if (peak != 2) begin bad++; $display("FAIL burst_peak got=%0d want=2", peak); end
    repeat (2) tick();
  endtask
  task automatic test_overflow();
    logic [7:0] seq [6];
    int novf = 0;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h55; seq[5] = 8'h66;
    for (int k = 0; k <= 203; k++) begin
      stb1 = (k < 6);
      if (k < 6) dat = seq[k];
      tick();
      if (ovf1) novf++;
      if (k == 4) begin
        total += 3;
        if (full1 !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", full1); end
        if (lvl1 !== 3'd4) begin bad++; $display("FAIL ovf_lvl4 got=%0d want=4", lvl1); end
        if (ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", ovf1); end
      end
      if (k == 5) begin
        total += 2;
        if (ovf1 !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", ovf1); end
        if (lvl1 !== 3'd4) begin bad++; $display("FAIL ovf_lvl_kept got=%0d want=4", lvl1); end
      end
      if (k == 6) begin
        total++;
        if (ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf1); end
      end
      if (k >= 2) begin
        total++;
        if (k <= 201 && ser1 !== exp_bit(seq[(k - 2) / 40], (k - 2) % 40)) begin
          bad++; $display("FAIL ovf_line t=%0d got=%b want=%b", k - 2, ser1, exp_bit(seq[(k - 2) / 40], (k - 2) % 40));
        end else if (k > 201 && ser1 !== 1'b1) begin
          bad++; $display("FAIL ovf_extra_frame k=%0d got=%b want=1", k, ser1);
        end
      end
      if (k == 200 || k == 201) begin
        total++;
        if (busy1 !== (k == 200)) begin bad++; $display("FAIL ovf_busy k=%0d got=%b want=%b", k, busy1, k == 200); end
      end
    end
    stb1 = 1'b0;
    total++;
    if (novf != 1) begin bad++; $display("FAIL ovf_count got=%0d want=1", novf); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] seq [3];
    seq[0] = 8'h00; seq[1] = 8'hAA; seq[2] = 8'hBB;
    for (int k = 0; k <= 19; k++) begin
      stb1 = (k < 3);
      if (k < 3) dat = seq[k];
      tick();
      if (k >= 2) begin
        total++;
        if (ser1 !== exp_bit(seq[0], k - 2)) begin
          bad++; $display("FAIL mid_line t=%0d got=%b want=%b", k - 2, ser1, exp_bit(seq[0], k - 2));
        end
      end
    end
    stb1 = 1'b0;
    total++;
    if (lvl1 !== 3'd2) begin bad++; $display("FAIL mid_lvl_before got=%0d want=2", lvl1); end
    rst = 1'b0;
    #1;
    total += 4;
    if (ser1 !== 1'b1) begin bad++; $display("FAIL mid_serial got=%b want=1", ser1); end
    if (lvl1 !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", lvl1); end
    if (busy1 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy1); end
    if (full1 !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", full1); end
    repeat (3) tick();
    rst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      total++;
      if (ser1 !== 1'b1 || busy1 !== 1'b0) begin
        bad++; $display("FAIL mid_after k=%0d serial=%b busy=%b want serial=1 busy=0", k, ser1, busy1);
      end
    end
  endtask
  task automatic test_stop2();
    logic [7:0] seq [2];
    seq[0] = 8'hFF; seq[1] = 8'h5A;
    for (int k = 0; k <= 91; k++) begin
      stb2 = (k < 2);
      if (k < 2) dat = seq[k];
      tick();
      if (k >= 2 && k <= 89) begin
        total++;
        if (ser2 !== exp_bit(seq[(k - 2) / 44], (k - 2) % 44)) begin
          bad++; $display("FAIL stop2_line t=%0d got=%b want=%b", k - 2, ser2, exp_bit(seq[(k - 2) / 44], (k - 2) % 44));
        end
      end
      if (k == 88 || k == 89) begin
        total++;
        if (busy2 !== (k == 88)) begin bad++; $display("FAIL stop2_busy k=%0d got=%b want=%b", k, busy2, k == 88); end
      end
      if (k >= 90) begin
        total++;
        if (ser2 !== 1'b1) begin bad++; $display("FAIL stop2_idle k=%0d got=%b want=1", k, ser2); end
      end
    end
    stb2 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_mid();
    test_stop2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
